// File: rtl/iq_capture_pkg.sv
// Shared types and helpers for the I/Q capture controller feeding the iq_ram sample buffer.
package iq_capture_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // I lands in the upper half of the RAM word so the CPU reads {I, Q}.
    function automatic logic [2*DEF_DATA_WIDTH-1:0] pack_iq(
        input logic [DEF_DATA_WIDTH-1:0] i_s,
        input logic [DEF_DATA_WIDTH-1:0] q_s
    );
        return {i_s, q_s};
    endfunction

endpackage

// File: rtl/iq_capture_decim.sv
// Decimation phase counter: strobes o_keep on every (decim+1)-th sample, first sample after clear always kept.
module iq_capture_decim (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       i_clr,
    input  logic [7:0] i_decim,
    input  logic       i_sample,
    output logic       o_keep
);

    logic [7:0] r_phase;

    // Down-counter: terminal count 0 means "keep this one", then reload with the ratio.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_phase <= 8'd0;
        end else if (i_clr) begin
            r_phase <= 8'd0;
        end else if (i_sample) begin
            r_phase <= (r_phase == 8'd0) ? i_decim : r_phase - 8'd1;
        end
    end

    assign o_keep = (r_phase == 8'd0);

endmodule

// File: rtl/iq_capture_ctrl.sv
// I/Q capture controller: packs valid I/Q pairs into RAM words and writes a programmed count into iq_ram.
// Optional sample decimation is enabled by defining IQ_CAPTURE_DECIM_EN.
//
// state      | meaning
// ST_IDLE    | waiting for start; count holds the last capture's total
// ST_CAPTURE | writing one word per kept data_en sample
// ST_DONE    | capture complete, done flag high until start or abort
module iq_capture_ctrl
    import iq_capture_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [DATA_WIDTH-1:0]   data_q,
    input  logic                    data_en,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH:0]     depth,
`ifdef IQ_CAPTURE_DECIM_EN
    input  logic [7:0]              decim,
`endif
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [2*DATA_WIDTH-1:0] ram_data,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     count
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_arm;
    logic                    w_write;
    logic                    w_keep;
    logic [ADDR_WIDTH:0]     w_depth_clamp;
    logic [ADDR_WIDTH:0]     w_count_inc;
    logic [ADDR_WIDTH:0]     r_depth_lat;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH-1:0]   r_addr_cnt;
    logic [ADDR_WIDTH-1:0]   r_ram_addr;
    logic [2*DATA_WIDTH-1:0] r_ram_data;
    logic                    r_ram_we;

    assign w_depth_clamp = (depth > DEPTH_MAX) ? DEPTH_MAX : depth;
    assign w_count_inc   = r_count + CNT_ONE;

`ifdef IQ_CAPTURE_DECIM_EN
    logic [7:0] r_decim_lat;

    iq_capture_decim u_decim (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .i_clr    (w_arm | abort),
        .i_decim  (r_decim_lat),
        .i_sample (data_en && (r_state == ST_CAPTURE)),
        .o_keep   (w_keep)
    );
`else
    assign w_keep = 1'b1;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort outranks start, so a coincident pair leaves the controller idle.
    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_arm       = 1'b1;
                    w_state_nxt = (w_depth_clamp == '0) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (data_en && w_keep) begin
                    w_write = 1'b1;
                    if (w_count_inc == r_depth_lat) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ram_addr/ram_data hold between writes; the address counter may wrap to 0 after the last word.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_addr_cnt  <= '0;
            r_count     <= '0;
            r_depth_lat <= '0;
`ifdef IQ_CAPTURE_DECIM_EN
            r_decim_lat <= 8'd0;
`endif
        end else begin
            r_ram_we <= w_write;
            if (w_arm) begin
                r_addr_cnt  <= '0;
                r_count     <= '0;
                r_depth_lat <= w_depth_clamp;
`ifdef IQ_CAPTURE_DECIM_EN
                r_decim_lat <= decim;
`endif
            end
            if (w_write) begin
                r_ram_addr <= r_addr_cnt;
                r_ram_data <= pack_iq(data_i, data_q);
                r_addr_cnt <= r_addr_cnt + ADDR_ONE;
                r_count    <= w_count_inc;
            end
        end
    end

    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign busy     = (r_state == ST_CAPTURE);
    assign done     = (r_state == ST_DONE);
    assign count    = r_count;

endmodule
